// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : branch_pkg
// Brief    : Branch condition codes and sequencer state encoding shared by the
//            branch sequencer, compare unit and control FSM.
// Revision : 1.0 - initial release
// ============================================================================
package branch_pkg;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        UPDATE = 2'd3
    } seq_state_t;

    // 010 and 011 are unassigned in the branch major opcode.
    function automatic logic is_illegal_funct3(input logic [2:0] f3);
        return (f3 == 3'b010) || (f3 == 3'b011);
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : branch_watchdog
// Brief    : 8-bit up-counter that flags when LIMIT-1 cycles have elapsed
//            since the last clear; saturates at that value.
// Revision : 1.0 - initial release
// ============================================================================
module branch_watchdog #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [7:0] c_last = 8'(LIMIT - 1);

    logic [7:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_expired = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/branch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : branch_sequencer
// Brief    : Issues a decoded conditional branch to the compare unit, waits
//            for its verdict (with watchdog) and emits the next-PC write.
//            Optional feature macro: BRANCH_MISALIGN_EXC_EN (misaligned
//            taken target raises exc instead of pc_wr).
// Revision : 1.0 - initial release
// ============================================================================
module branch_sequencer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_pc,
    input  logic [31:0] req_imm,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    output logic        cmp_start,
    output logic [31:0] cmp_rs1,
    output logic [31:0] cmp_rs2,
    output logic [2:0]  cmp_funct3,
    input  logic        cmp_done,
    input  logic        cmp_jump,
    output logic        pc_wr,
    output logic [31:0] next_pc,
    output logic        taken,
    output logic        illegal,
    output logic        fault,
    output logic        exc,
    output logic [31:0] exc_tval
);

    import branch_pkg::*;

    seq_state_t  r_state, w_state_next;

    logic [31:0] r_pc, r_imm, r_rs1, r_rs2;
    logic [2:0]  r_funct3;

    logic        r_req_ready, r_cmp_start, r_pc_wr, r_taken, r_illegal, r_fault, r_exc;
    logic [31:0] r_next_pc, r_exc_tval;

    logic        w_capture, w_jump, w_expired;
    logic        w_cmp_start, w_pc_wr, w_taken, w_illegal, w_fault, w_exc;
    logic [31:0] w_next_pc, w_exc_tval;

    // Both sums wrap modulo 2^32 by construction of the 32-bit adders.
    logic [31:0] w_target, w_seq_pc;
    assign w_target = r_pc + r_imm;
    assign w_seq_pc = r_pc + 32'd4;

    branch_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (r_state != WAIT),
        .i_enable  (r_state == WAIT),
        .o_expired (w_expired)
    );

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_jump       = 1'b0;
        w_cmp_start  = 1'b0;
        w_pc_wr      = 1'b0;
        w_next_pc    = '0;
        w_taken      = 1'b0;
        w_illegal    = 1'b0;
        w_fault      = 1'b0;
        w_exc        = 1'b0;
        w_exc_tval   = '0;

        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_capture = 1'b1;
                    if (is_illegal_funct3(req_funct3)) begin
                        w_illegal = 1'b1;
                    end else begin
                        w_state_next = ISSUE;
                        w_cmp_start  = 1'b1;
                    end
                end
            end
            ISSUE: begin
                w_state_next = WAIT;
            end
            WAIT: begin
                // A verdict arriving on the expiry cycle takes precedence.
                if (cmp_done || w_expired) begin
                    w_state_next = UPDATE;
                    w_jump       = cmp_done && cmp_jump;
                    w_fault      = !cmp_done;
`ifdef BRANCH_MISALIGN_EXC_EN
                    if (w_jump && (w_target[1:0] != 2'b00)) begin
                        w_exc      = 1'b1;
                        w_exc_tval = w_target;
                    end else begin
                        w_pc_wr   = 1'b1;
                        w_next_pc = w_jump ? w_target : w_seq_pc;
                        w_taken   = w_jump;
                    end
`else
                    w_pc_wr   = 1'b1;
                    w_next_pc = w_jump ? w_target : w_seq_pc;
                    w_taken   = w_jump;
`endif
                end
            end
            UPDATE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Outputs are computed one cycle ahead so every port comes straight off a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pc        <= '0;
            r_imm       <= '0;
            r_funct3    <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_req_ready <= 1'b1;
            r_cmp_start <= 1'b0;
            r_pc_wr     <= 1'b0;
            r_next_pc   <= '0;
            r_taken     <= 1'b0;
            r_illegal   <= 1'b0;
            r_fault     <= 1'b0;
            r_exc       <= 1'b0;
            r_exc_tval  <= '0;
        end else begin
            r_state     <= w_state_next;
            if (w_capture) begin
                r_pc     <= req_pc;
                r_imm    <= req_imm;
                r_funct3 <= req_funct3;
                r_rs1    <= req_rs1;
                r_rs2    <= req_rs2;
            end
            r_req_ready <= (w_state_next == IDLE);
            r_cmp_start <= w_cmp_start;
            r_pc_wr     <= w_pc_wr;
            r_next_pc   <= w_next_pc;
            r_taken     <= w_taken;
            r_illegal   <= w_illegal;
            r_fault     <= w_fault;
            r_exc       <= w_exc;
            r_exc_tval  <= w_exc_tval;
        end
    end

    assign req_ready  = r_req_ready;
    assign cmp_start  = r_cmp_start;
    assign cmp_rs1    = r_rs1;
    assign cmp_rs2    = r_rs2;
    assign cmp_funct3 = r_funct3;
    assign pc_wr      = r_pc_wr;
    assign next_pc    = r_next_pc;
    assign taken      = r_taken;
    assign illegal    = r_illegal;
    assign fault      = r_fault;
    assign exc        = r_exc;
    assign exc_tval   = r_exc_tval;

endmodule
`default_nettype wire
